// File: rtl/mac.sv
// Two-stage pipelined multiply-accumulate: result = (in1*in2 + acc) mod 2^WIDTH.
// Stage 1 registers the truncated product and the addend. Stage 2 adds them
// and registers the result together with zero/carry/overflow/negative flags.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous active-high reset
//   in_valid      operation present on in1/in2/acc this cycle
//   in1, in2      unsigned multiplicand / multiplier
//   acc           addend supplied by the caller
//   result        registered sum, low WIDTH bits
//   out_valid     one-cycle pulse when result/flags were updated
//   zero_flag     result == 0
//   carry_flag    carry out of the final addition
//   overflow_flag two's-complement overflow of the final addition
//   negative_flag result MSB
module mac #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             negative_flag
);

    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] prod_q;
    logic [WIDTH-1:0] acc_q;
    logic             valid_q;
    logic [WIDTH:0]   sum;

    // Product is taken at WIDTH bits, so upper product bits never reach
    // the adder or the flags.
    assign prod = in1 * in2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q  <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                prod_q <= prod;
                acc_q  <= acc;
            end
        end
    end

    assign sum = {1'b0, prod_q} + {1'b0, acc_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result        <= '0;
            out_valid     <= 1'b0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            negative_flag <= 1'b0;
        end else begin
            out_valid <= valid_q;
            if (valid_q) begin
                result        <= sum[WIDTH-1:0];
                zero_flag     <= (sum[WIDTH-1:0] == '0);
                carry_flag    <= sum[WIDTH];
                // Operands of equal sign producing a sum of the other sign.
                overflow_flag <= (prod_q[WIDTH-1] == acc_q[WIDTH-1]) &&
                                 (sum[WIDTH-1] != prod_q[WIDTH-1]);
                negative_flag <= sum[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_mac.sv
module tb_mac;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in1, in2, acc;
    logic [W-1:0] result;
    logic         out_valid, zero_flag, carry_flag, overflow_flag, negative_flag;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         z, c, v, n;
        int           due;
    } exp_t;

    exp_t q[$];
    exp_t held;

    mac #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in1(in1), .in2(in2), .acc(acc),
        .result(result), .out_valid(out_valid),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .overflow_flag(overflow_flag), .negative_flag(negative_flag)
    );

    always #5 clk = ~clk;

    // Arithmetic model: 64-bit products and sums, signed range test for overflow.
    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c);
        exp_t e;
        longint unsigned full, p, s;
        longint sp, sc, ss;
        full = longint'(a) * longint'(b);
        p    = full % 64'h1_0000_0000;
        s    = p + longint'(c);
        sp   = (p >= 64'h8000_0000) ? longint'(p) - 64'sh1_0000_0000 : longint'(p);
        sc   = (c >= 32'h8000_0000) ? longint'(c) - 64'sh1_0000_0000 : longint'(c);
        ss   = sp + sc;
        e.r  = s[W-1:0];
        e.c  = (s >= 64'h1_0000_0000);
        e.v  = (ss > 64'sh7FFF_FFFF) || (ss < -64'sh8000_0000);
        e.z  = (e.r == 0);
        e.n  = (s % 64'h1_0000_0000) >= 64'h8000_0000;
        e.due = 0;
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Record accepted operations; they are due after the following edge.
    always @(posedge clk) begin
        exp_t e;
        cycle++;
        if (rst) begin
            q.delete();
        end else if (in_valid) begin
            e = model(in1, in2, acc);
            e.due = cycle + 1;
            q.push_back(e);
        end
    end

    // Compare every cycle, on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cycle) begin
            held = q.pop_front();
            chk("out_valid", 64'(out_valid), 64'd1);
        end else begin
            chk("out_valid_idle", 64'(out_valid), 64'd0);
        end
        chk("result",   64'(result),        64'(held.r));
        chk("zero",     64'(zero_flag),     64'(held.z));
        chk("carry",    64'(carry_flag),    64'(held.c));
        chk("overflow", 64'(overflow_flag), 64'(held.v));
        chk("negative", 64'(negative_flag), 64'(held.n));
    end

    task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c);
        @(negedge clk); #1;
        in_valid = 1'b1; in1 = a; in2 = b; acc = c;
    endtask

    // Idle cycle with junk on the data inputs; it must not be sampled.
    task automatic idle();
        @(negedge clk); #1;
        in_valid = 1'b0; in1 = $urandom; in2 = $urandom; acc = $urandom;
    endtask

    // Issue one op, then check the outputs against hand-computed literals.
    task automatic single(string name, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c,
                          logic [W-1:0] r, logic z, logic cy, logic v, logic n);
        issue(a, b, c);
        idle();
        @(negedge clk);
        chk({name, "_ov"}, 64'(out_valid), 64'd1);
        chk({name, "_r"},  64'(result), 64'(r));
        chk({name, "_z"},  64'(zero_flag), 64'(z));
        chk({name, "_c"},  64'(carry_flag), 64'(cy));
        chk({name, "_v"},  64'(overflow_flag), 64'(v));
        chk({name, "_n"},  64'(negative_flag), 64'(n));
    endtask

    initial begin
        held = '{r: '0, z: 1'b0, c: 1'b0, v: 1'b0, n: 1'b0, due: 0};
        rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; acc = '0;
        #1;
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_ovalid", 64'(out_valid), 64'd0);
        chk("rst_flags", 64'({zero_flag, carry_flag, overflow_flag, negative_flag}), 64'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) idle();

        // Sweeps with acc=0 and acc=1, one op per cycle.
        for (int unsigned i = 0; i < 10; i++) issue(i, i, 0);
        for (int unsigned i = 0; i < 10; i++) issue(i, i, 1);
        repeat (3) idle();

        // Boundary literals.
        single("carry", 32'hFFFF_FFFF, 32'd1, 32'd1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        single("ovf",   32'h7FFF_FFFF, 32'd1, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        single("trunc", 32'h0001_0000, 32'h0001_0000, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        single("sq10",  32'd10, 32'd10, 32'd0, 32'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // Back-to-back mixed operations.
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000);
        issue(32'h8000_0000, 32'd1, 32'h8000_0000);
        issue(32'd123456, 32'd789, 32'hDEAD_BEEF);
        issue(32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
        repeat (4) idle();

        // Reset while an op is in stage 1.
        issue(32'd3, 32'd3, 32'd0);
        idle();
        #2 rst = 1'b1;
        q.delete();
        held = '{r: '0, z: 1'b0, c: 1'b0, v: 1'b0, n: 1'b0, due: 0};
        #1;
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_ovalid", 64'(out_valid), 64'd0);
        chk("midrst_flags", 64'({zero_flag, carry_flag, overflow_flag, negative_flag}), 64'd0);
        @(negedge clk); #1 rst = 1'b0;
        repeat (3) idle();
        single("after_rst", 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) idle();

        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d ops still pending, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac.md
MAC -- requirements
Module: MAC

Interface
REQ-001 Parameter WIDTH, default 32: operand, accumulator and result width; all values below assume WIDTH=32.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 in_valid  input  1  high when in1, in2 and acc hold an operation to be accepted this cycle.
REQ-005 in1  input  WIDTH  multiplicand, unsigned.
REQ-006 in2  input  WIDTH  multiplier, unsigned.
REQ-007 acc  input  WIDTH  addend, supplied by the caller; there is no internal feedback accumulator.
REQ-008 result  output  WIDTH  registered value of (in1*in2 + acc) mod 2^WIDTH.
REQ-009 out_valid  output  1  one-cycle pulse marking result and flags as updated for one operation.
REQ-010 zero_flag  output  1  high when result == 0.
REQ-011 carry_flag  output  1  carry out of the final addition.
REQ-012 overflow_flag  output  1  two's-complement overflow of the final addition.
REQ-013 negative_flag  output  1  equal to result[WIDTH-1].

Function
REQ-014 Stage 1: on a clock edge with in_valid=1, the block SHALL register the low WIDTH bits of the unsigned product P = (in1*in2)[WIDTH-1:0], register acc, and set a stage-1 valid bit; with in_valid=0 the stage-1 valid bit SHALL clear.
REQ-015 Stage 2: on each clock edge with the stage-1 valid bit set, the block SHALL compute S = P + acc as a WIDTH+1-bit sum, load result = S[WIDTH-1:0], and update all four flags.
REQ-016 Flag computation:
- carry_flag = S[WIDTH].
- overflow_flag = 1 iff P[MSB] == acc[MSB] and S[WIDTH-1] != P[MSB].
- zero_flag and negative_flag are derived from the new result.
REQ-017 Latency SHALL be 2 cycles: an operation accepted at edge N SHALL appear on result and flags, with out_valid=1, after edge N+1.
REQ-018 Throughput SHALL be one operation per cycle; back-to-back in_valid pulses SHALL produce back-to-back out_valid pulses in issue order.
REQ-019 There is no backpressure; the consumer SHALL sample an output on the cycle its out_valid is high.
REQ-020 When no operation completes in a cycle, result and all flags SHALL hold their previous values and out_valid SHALL be 0.
REQ-021 Product bits at and above WIDTH SHALL be discarded and SHALL NOT affect carry_flag or overflow_flag.
REQ-022 Inputs SHALL be sampled only on edges with in_valid=1; input changes while in_valid=0 SHALL have no effect.

Reset
REQ-023 While rst=1, the following SHALL be 0, asynchronously, independent of clk:
- result, out_valid, zero_flag, carry_flag, overflow_flag, negative_flag;
- the stage-1 valid bit and all stage-1 registers.
REQ-024 An operation in flight when rst asserts SHALL be discarded and SHALL never produce an out_valid pulse.
REQ-025 After rst deasserts, the first in_valid=1 edge SHALL be accepted normally, with its result appearing 2 cycles later.

Verification
REQ-026 Sweep with acc=0: in1=in2=i for i=0..9, one operation per cycle. Required: results 0,1,4,...,81 on consecutive out_valid pulses; zero_flag=1 only for i=0; carry_flag, overflow_flag and negative_flag all 0.
REQ-027 Sweep with acc=1: in1=in2=i for i=0..9. Required: results 1,2,5,...,82; all flags 0.
REQ-028 Carry boundary: in1=0xFFFFFFFF, in2=1, acc=1. Required: result=0, carry_flag=1, zero_flag=1, overflow_flag=0, negative_flag=0.
REQ-029 Overflow boundary: in1=0x7FFFFFFF, in2=1, acc=1. Required: result=0x80000000, overflow_flag=1, negative_flag=1, carry_flag=0.
REQ-030 Product truncation: in1=in2=0x00010000, acc=5. Required: result=5, all flags 0.
REQ-031 Reset mid-operation: issue in1=3, in2=3, acc=0, then assert rst asynchronously between clock edges before the result appears. Required: all outputs 0 immediately; no out_valid pulse after release; a subsequent 2*2+0 operation yields result=4 two cycles after acceptance.
